// File: rtl/mdu_seq_controller.sv
// Iterative multiply/divide sequencer: one shift-add or shift-subtract step per cycle,
// with div-by-zero/overflow fast paths, signed-divide fix-up, result hold under cpu_busy and flush abort.
module mdu_seq_controller #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       funct3,
  input  logic             mdu_in_valid,
  input  logic             divisor_zero,
  input  logic             div_ovf,
  input  logic             cpu_busy,
  input  logic             flush,
  output logic [2:0]       op_q,
  output logic             m_wen,
  output logic             d_wen,
  output logic             fix_en,
  output logic [1:0]       res_sel,
  output logic [CNT_W-1:0] cnt_o,
  output logic             mdu_busy,
  output logic             mdu_out_valid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       op_nxt;
  logic [1:0]       res_sel_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      op_q    <= '0;
      res_sel <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      op_q    <= op_nxt;
      res_sel <= res_sel_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    op_nxt      = op_q;
    res_sel_nxt = res_sel;
    // op_q and res_sel survive a flush so the datapath mux stays put until the next accept
    if (state != S_IDLE && flush) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mdu_in_valid && !flush) begin
            op_nxt  = funct3;
            cnt_nxt = '0;
            if (!funct3[2]) begin
              state_nxt   = S_MUL;
              res_sel_nxt = 2'd0;
            end else if (divisor_zero) begin
              state_nxt   = S_DONE;
              res_sel_nxt = 2'd1;
            end else if (!funct3[0] && div_ovf) begin
              state_nxt   = S_DONE;
              res_sel_nxt = 2'd2;
            end else begin
              state_nxt   = S_DIV;
              res_sel_nxt = 2'd0;
            end
          end
        end
        S_MUL: begin
          if (cnt == CNT_LAST) begin
            state_nxt = S_DONE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        S_DIV: begin
          if (cnt == CNT_LAST) begin
            state_nxt = op_q[0] ? S_DONE : S_FIX;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        S_FIX:  state_nxt = S_DONE;
        S_DONE: if (!cpu_busy) state_nxt = S_IDLE;
        default: begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign m_wen         = (state == S_MUL);
  assign d_wen         = (state == S_DIV);
  assign fix_en        = (state == S_FIX);
  assign mdu_out_valid = (state == S_DONE);
  assign mdu_busy      = (state != S_IDLE);
  assign cnt_o         = cnt;

endmodule

// File: tb/tb_mdu_seq_controller.sv
// Directed bench for mdu_seq_controller at XLEN = 32: vector table of operations plus
// hand sequences for back-pressure, flush and mid-operation reset.
module tb_mdu_seq_controller;
  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(XLEN);

  logic             clk = 0;
  logic             rst_n;
  logic [2:0]       funct3;
  logic             mdu_in_valid, divisor_zero, div_ovf, cpu_busy, flush;
  logic [2:0]       op_q;
  logic             m_wen, d_wen, fix_en;
  logic [1:0]       res_sel;
  logic [CNT_W-1:0] cnt_o;
  logic             mdu_busy, mdu_out_valid;

  mdu_seq_controller #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .funct3(funct3), .mdu_in_valid(mdu_in_valid),
    .divisor_zero(divisor_zero), .div_ovf(div_ovf), .cpu_busy(cpu_busy), .flush(flush),
    .op_q(op_q), .m_wen(m_wen), .d_wen(d_wen), .fix_en(fix_en), .res_sel(res_sel),
    .cnt_o(cnt_o), .mdu_busy(mdu_busy), .mdu_out_valid(mdu_out_valid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single cycle, then follow the operation until mdu_out_valid.
  task automatic run_op(input logic [2:0] f3, input logic dz, input logic ovf,
                        output int lat, output int mc, output int dc, output int fc,
                        output int cnt_bad, output int oh_bad);
    funct3 = f3; divisor_zero = dz; div_ovf = ovf; mdu_in_valid = 1;
    step;
    mdu_in_valid = 0; divisor_zero = 0; div_ovf = 0;
    lat = 1; mc = 0; dc = 0; fc = 0; cnt_bad = 0; oh_bad = 0;
    while (!mdu_out_valid && lat < 100) begin
      if (int'(m_wen) + int'(d_wen) + int'(fix_en) > 1) oh_bad++;
      if (m_wen) begin
        if (int'(cnt_o) != mc) cnt_bad++;
        mc++;
      end
      if (d_wen) begin
        if (int'(cnt_o) != dc) cnt_bad++;
        dc++;
      end
      if (fix_en) fc++;
      step;
      lat++;
    end
    if (!mdu_out_valid) lat = -1;
    if (m_wen || d_wen || fix_en) oh_bad++;
  endtask

  typedef struct {
    logic [2:0] f3;
    logic       dz;
    logic       ovf;
    int         lat;
    int         mc;
    int         dc;
    int         fc;
    int         rs;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int lat, mc, dc, fc, cb, ob, vcnt, guard;
    vecs[0]  = '{3'b000, 1'b0, 1'b0, 33, 32, 0,  0, 0};  // MUL
    vecs[1]  = '{3'b001, 1'b0, 1'b0, 33, 32, 0,  0, 0};  // MULH
    vecs[2]  = '{3'b100, 1'b0, 1'b0, 34, 0,  32, 1, 0};  // DIV
    vecs[3]  = '{3'b101, 1'b0, 1'b0, 33, 0,  32, 0, 0};  // DIVU
    vecs[4]  = '{3'b110, 1'b0, 1'b0, 34, 0,  32, 1, 0};  // REM
    vecs[5]  = '{3'b111, 1'b0, 1'b0, 33, 0,  32, 0, 0};  // REMU
    vecs[6]  = '{3'b101, 1'b1, 1'b0, 1,  0,  0,  0, 1};  // DIVU /0
    vecs[7]  = '{3'b100, 1'b0, 1'b1, 1,  0,  0,  0, 2};  // DIV overflow
    vecs[8]  = '{3'b101, 1'b0, 1'b1, 33, 0,  32, 0, 0};  // DIVU ignores ovf
    vecs[9]  = '{3'b110, 1'b1, 1'b1, 1,  0,  0,  0, 1};  // REM: /0 wins over ovf
    vecs[10] = '{3'b000, 1'b1, 1'b1, 33, 32, 0,  0, 0};  // MUL ignores div flags
    vecs[11] = '{3'b111, 1'b0, 1'b1, 33, 0,  32, 0, 0};  // REMU ignores ovf

    rst_n = 0; funct3 = 0; mdu_in_valid = 0; divisor_zero = 0; div_ovf = 0;
    cpu_busy = 0; flush = 0;
    step; step;
    check("reset_busy", int'(mdu_busy), 0);
    check("reset_valid", int'(mdu_out_valid), 0);
    check("reset_enables", int'({m_wen, d_wen, fix_en}), 0);
    check("reset_cnt", int'(cnt_o), 0);
    check("reset_op_q", int'(op_q), 0);
    check("reset_res_sel", int'(res_sel), 0);
    rst_n = 1;
    step;

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].f3, vecs[i].dz, vecs[i].ovf, lat, mc, dc, fc, cb, ob);
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d_m_wen_cycles", i), mc, vecs[i].mc);
      check($sformatf("v%0d_d_wen_cycles", i), dc, vecs[i].dc);
      check($sformatf("v%0d_fix_cycles", i), fc, vecs[i].fc);
      check($sformatf("v%0d_cnt_seq_errs", i), cb, 0);
      check($sformatf("v%0d_onehot_errs", i), ob, 0);
      check($sformatf("v%0d_res_sel", i), int'(res_sel), vecs[i].rs);
      check($sformatf("v%0d_op_q", i), int'(op_q), int'(vecs[i].f3));
      check($sformatf("v%0d_busy_done", i), int'(mdu_busy), 1);
      step;
      check($sformatf("v%0d_busy_after", i), int'(mdu_busy), 0);
      check($sformatf("v%0d_valid_after", i), int'(mdu_out_valid), 0);
    end

    // Back-pressure: result held while cpu_busy, request during DONE ignored.
    cpu_busy = 1;
    run_op(3'b000, 1'b0, 1'b0, lat, mc, dc, fc, cb, ob);
    check("bp_latency", lat, 33);
    vcnt = 1;
    funct3 = 3'b100; mdu_in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      step;
      if (mdu_out_valid) vcnt++;
      check($sformatf("bp_op_q_%0d", i), int'(op_q), 0);
      check($sformatf("bp_res_sel_%0d", i), int'(res_sel), 0);
    end
    check("bp_valid_cycles", vcnt, 6);
    cpu_busy = 0;
    step;
    check("bp_exit_idle", int'(mdu_busy), 0);
    mdu_in_valid = 0;
    step;
    check("bp_no_accept_on_exit", int'(mdu_busy), 0);
    check("bp_no_accept_op_q", int'(op_q), 0);

    // Flush mid-divide.
    funct3 = 3'b100; mdu_in_valid = 1;
    step;
    mdu_in_valid = 0;
    guard = 0;
    while (!(d_wen && cnt_o == 5'd10) && guard < 100) begin
      step;
      guard++;
    end
    check("flush_reached_cnt10", int'(d_wen && cnt_o == 5'd10), 1);
    flush = 1;
    step;
    flush = 0;
    check("flush_busy", int'(mdu_busy), 0);
    check("flush_d_wen", int'(d_wen), 0);
    check("flush_cnt", int'(cnt_o), 0);
    check("flush_op_q_kept", int'(op_q), 4);
    vcnt = 0;
    for (int i = 0; i < 40; i++) begin
      step;
      if (mdu_out_valid || mdu_busy) vcnt++;
    end
    check("flush_no_result", vcnt, 0);
    run_op(3'b000, 1'b0, 1'b0, lat, mc, dc, fc, cb, ob);
    check("post_flush_mul_latency", lat, 33);
    check("post_flush_mul_cycles", mc, 32);
    step;

    // Synchronous reset mid-multiply, with a request in the same cycle.
    funct3 = 3'b011; mdu_in_valid = 1;
    step;
    mdu_in_valid = 0;
    guard = 0;
    while (!(m_wen && cnt_o == 5'd20) && guard < 100) begin
      step;
      guard++;
    end
    check("rst_reached_cnt20", int'(m_wen && cnt_o == 5'd20), 1);
    rst_n = 0; funct3 = 3'b100; mdu_in_valid = 1;
    step;
    check("rst_busy", int'(mdu_busy), 0);
    check("rst_cnt", int'(cnt_o), 0);
    check("rst_op_q", int'(op_q), 0);
    check("rst_outputs", int'({m_wen, d_wen, fix_en, mdu_out_valid, res_sel}), 0);
    rst_n = 1; mdu_in_valid = 0;
    step;
    check("rst_req_not_accepted", int'(mdu_busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mdu_seq_controller.md
Name: mdu_seq_controller

Overview:
- Parametrised iterative multiply/divide sequencer for the RV M-extension MDU.
- Controls both the shift-add multiplier and the restoring divider datapaths, one iteration per cycle.
- Handles div-by-zero and signed-overflow fast paths, signed-result fix-up, CPU back-pressure and pipeline flush.
- Sits between the CPU execute stage and the MDU datapath. Its outputs gate the datapath write enables and result mux.

Parameters:
- XLEN, 32, operand width and iteration count for both multiply and divide. Legal values are 4 and above.
- CNT_W, $clog2(XLEN), width of the iteration counter. Derived; not to be overridden.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- funct3  in  3  M-extension funct3. Bit 2 = 0 selects MUL*, bit 2 = 1 selects DIV/REM. For divide, bit 0 = 0 means signed.
- mdu_in_valid  in  1  operation request, sampled only in IDLE
- divisor_zero  in  1  datapath flag: divisor == 0, valid together with mdu_in_valid
- div_ovf  in  1  datapath flag: dividend == most-negative and divisor == -1
- cpu_busy  in  1  CPU cannot consume the result this cycle
- flush  in  1  abort the current operation
- op_q  out  3  funct3 latched at accept
- m_wen  out  1  multiplier iteration enable
- d_wen  out  1  divider iteration enable (remainder/quotient shift-subtract)
- fix_en  out  1  signed-divide sign-correction enable
- res_sel  out  2  result select: 0 = datapath, 1 = div-by-zero constants, 2 = overflow constants
- cnt_o  out  CNT_W  current iteration index
- mdu_busy  out  1  high whenever the state is not IDLE
- mdu_out_valid  out  1  result valid

Behaviour:
- States: IDLE, MUL, DIV, FIX, DONE. All outputs are decoded from registered state, op_q, cnt and res_sel; there are no combinational paths from inputs to outputs.
- Reset: on any posedge with rst_n = 0, regardless of state, the block goes to state IDLE with cnt = 0, op_q = 0 and res_sel = 0. All enables, mdu_busy and mdu_out_valid are 0.
- IDLE, with mdu_in_valid = 1 and flush = 0: op_q <= funct3 and cnt <= 0. The next state is decided in this order:
  - funct3[2] = 0 -> MUL, res_sel <= 0.
  - funct3[2] = 1 and divisor_zero = 1 -> DONE, res_sel <= 1.
  - funct3[2] = 1, funct3[0] = 0 and div_ovf = 1 -> DONE, res_sel <= 2.
  - Otherwise -> DIV, res_sel <= 0.
- In IDLE, requests are ignored when flush = 1.
- MUL: m_wen = 1 and cnt increments every cycle. When cnt == XLEN-1, the next state is DONE and cnt <= 0.
- DIV: d_wen = 1 and cnt increments every cycle. When cnt == XLEN-1, the next state is FIX if op_q[0] = 0, otherwise DONE; cnt <= 0.
- FIX: fix_en = 1 for exactly one cycle, then DONE.
- DONE: mdu_out_valid = 1. If cpu_busy = 0, the next state is IDLE; otherwise the block holds in DONE with all outputs stable.
- Latency, counted from the accept edge to the first mdu_out_valid cycle:
  - MUL*: XLEN+1 cycles.
  - DIVU/REMU: XLEN+1 cycles.
  - DIV/REM: XLEN+2 cycles.
  - Fast paths: 1 cycle.
- Counter: cnt never exceeds XLEN-1 and is cleared on every accept and every exit. No wrap-around is possible. cnt_o = cnt.
- flush: from any non-IDLE state, the next state is IDLE and cnt <= 0. Enables drop the cycle after flush is sampled. flush in DONE discards the result. res_sel and op_q keep their values until the next accept.
- A new request is never accepted in the same cycle that DONE exits. The earliest next accept is the cycle after the return to IDLE.
- m_wen, d_wen, fix_en and mdu_out_valid are mutually exclusive (one-hot or all zero) in every cycle.

Test Plan (XLEN = 32):
- MUL, funct3 = 000, one-cycle valid -> m_wen high for exactly 32 cycles (cnt_o 0..31), mdu_out_valid 1 cycle after, res_sel = 0, mdu_busy low the cycle after DONE.
- DIV, funct3 = 100, divisor_zero = 0, div_ovf = 0 -> d_wen for 32 cycles, fix_en for 1 cycle, then mdu_out_valid; total 34 cycles. The same sequence with REMU (funct3 = 111) gives no fix_en and 33 cycles.
- DIVU with divisor_zero = 1 -> DONE on the next cycle, res_sel = 1, no d_wen pulses. DIV with div_ovf = 1 -> res_sel = 2. DIVU with div_ovf = 1 -> normal 33-cycle path.
- MUL with cpu_busy held high for 5 cycles in DONE -> mdu_out_valid held for 6 cycles with op_q and res_sel stable, then IDLE. A request asserted during DONE is ignored.
- DIV with flush at cnt_o = 10 -> IDLE on the next cycle, d_wen low, no mdu_out_valid. A subsequent MUL completes normally.
- rst_n low for 1 cycle mid-MUL (cnt_o = 20) -> after that edge: IDLE, cnt_o = 0, op_q = 0 and all outputs 0. A valid request in the same cycle as rst_n low is not accepted.
